// File: rtl/demux1_4_stream.sv
// demux1_4_stream
// ---------------
// Routes a single valid/ready input stream to one of four output channels.
// The destination is chosen per beat by 'sel'. Every channel owns a
// one-entry output register, so a consumer that stalls only blocks beats
// addressed to its own channel; beats for the other channels keep flowing.
//
// Ports
//   clk                 system clock, rising-edge active
//   rst                 synchronous active-high reset
//   sel[1:0]            destination channel of the current input beat
//   sin[DW-1:0]         input data
//   sin_vld             input beat valid
//   sin_rdy             block can accept the input beat this cycle
//   p0..p3[DW-1:0]      channel data (registered)
//   p0_vld..p3_vld      channel holds a valid beat (registered)
//   p0_rdy..p3_rdy      consumer accepts the beat held on the channel
//   pend[3:0]           bit k mirrors pk_vld
module demux1_4_stream #(
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    sel,
  input  logic [DW-1:0] sin,
  input  logic          sin_vld,
  output logic          sin_rdy,
  output logic [DW-1:0] p0,
  output logic [DW-1:0] p1,
  output logic [DW-1:0] p2,
  output logic [DW-1:0] p3,
  output logic          p0_vld,
  output logic          p1_vld,
  output logic          p2_vld,
  output logic          p3_vld,
  input  logic          p0_rdy,
  input  logic          p1_rdy,
  input  logic          p2_rdy,
  input  logic          p3_rdy,
  output logic [3:0]    pend
);

  logic [DW-1:0] d_q [4];
  logic [DW-1:0] d_d [4];
  logic [3:0]    v_q;
  logic [3:0]    v_d;
  logic [3:0]    p_rdy_vec;
  logic          accept;

  assign p_rdy_vec = {p3_rdy, p2_rdy, p1_rdy, p0_rdy};

  // The selected channel has room if it is empty or is being drained on this
  // same edge. Deliberately independent of sin_vld so no valid->ready loop
  // is formed through this block.
  always_comb begin
    sin_rdy = !rst && (!v_q[sel] || p_rdy_vec[sel]);
    accept  = sin_vld && sin_rdy;
  end

  // Next-state for every channel. A drain clears the valid flag, but an
  // accept into the same channel on the same edge wins, which lets one
  // channel sustain a beat every cycle. Data only changes on an accept, so
  // a stalled channel holds its beat stable.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      d_d[k] = d_q[k];
      v_d[k] = v_q[k];
      if (v_q[k] && p_rdy_vec[k]) begin
        v_d[k] = 1'b0;
      end
      if (accept && (sel == 2'(k))) begin
        d_d[k] = sin;
        v_d[k] = 1'b1;
      end
    end
  end

  // Channel registers; reset discards any buffered beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < 4; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

  assign p0     = d_q[0];
  assign p1     = d_q[1];
  assign p2     = d_q[2];
  assign p3     = d_q[3];
  assign p0_vld = v_q[0];
  assign p1_vld = v_q[1];
  assign p2_vld = v_q[2];
  assign p3_vld = v_q[3];
  assign pend   = v_q;

endmodule

// File: tb/tb_demux1_4_stream.sv
// tb_demux1_4_stream
// ------------------
// Self-checking bench for demux1_4_stream. A per-channel reference queue
// holds the beats the block should currently be buffering: a beat is pushed
// when the bench sees it accepted and popped when the consumer takes it.
// Inputs change 1 time unit after a rising edge; outputs are sampled 2 time
// units later, well away from the next edge.
module tb_demux1_4_stream;

  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    sel;
  logic [DW-1:0] sin;
  logic          sin_vld;
  logic          sin_rdy;
  logic [DW-1:0] p0, p1, p2, p3;
  logic          p0_vld, p1_vld, p2_vld, p3_vld;
  logic [3:0]    rdy;
  logic [3:0]    pend;

  logic [DW-1:0] p_arr [4];
  logic [3:0]    vld_v;

  logic [DW-1:0] exp_q [4][$];

  int n_checks = 0;
  int n_fail   = 0;

  demux1_4_stream #(.DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .sin     (sin),
    .sin_vld (sin_vld),
    .sin_rdy (sin_rdy),
    .p0      (p0),
    .p1      (p1),
    .p2      (p2),
    .p3      (p3),
    .p0_vld  (p0_vld),
    .p1_vld  (p1_vld),
    .p2_vld  (p2_vld),
    .p3_vld  (p3_vld),
    .p0_rdy  (rdy[0]),
    .p1_rdy  (rdy[1]),
    .p2_rdy  (rdy[2]),
    .p3_rdy  (rdy[3]),
    .pend    (pend)
  );

  always #5 clk = ~clk;

  assign p_arr[0] = p0;
  assign p_arr[1] = p1;
  assign p_arr[2] = p2;
  assign p_arr[3] = p3;
  assign vld_v    = {p3_vld, p2_vld, p1_vld, p0_vld};

  // Hard stop in case something wedges the stimulus.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference ready: the addressed channel is empty or drains on this edge.
  function automatic logic model_rdy();
    return !rst && ((exp_q[sel].size() == 0) || rdy[sel]);
  endfunction

  // Advance one clock: decide from the reference model and the current
  // inputs what the edge does, wait for it, update the queues.
  task automatic tick();
    logic       acc;
    logic [3:0] drn;
    acc = sin_vld && model_rdy();
    for (int k = 0; k < 4; k++) drn[k] = (exp_q[k].size() != 0) && rdy[k];
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) exp_q[k].delete();
    end else begin
      for (int k = 0; k < 4; k++) if (drn[k]) void'(exp_q[k].pop_front());
      if (acc) exp_q[sel].push_back(sin);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 2'd0; sin = '0; sin_vld = 1'b1; rdy = 4'b1111;
    #2;
    n_checks++;
    if (sin_rdy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_rdy_pre: got %b expected 0", sin_rdy);
    end
    tick();
    #2;
    n_checks++;
    if (sin_rdy !== 1'b0 || pend !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL reset_hold: sin_rdy=%b pend=%b expected 0/0000", sin_rdy, pend);
    end
    tick();
    rst = 1'b0; sin_vld = 1'b0;
    #2;
    n_checks++;
    if (sin_rdy !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_rdy_post: got %b expected 1", sin_rdy);
    end
    n_checks++;
    if (pend !== 4'b0000 || vld_v !== 4'b0000 || {p3, p2, p1, p0} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_outputs: pend=%b data=%h expected 0000/0", pend, {p3, p2, p1, p0});
    end
    tick();
  endtask

  task automatic test_routing();
    logic [DW-1:0] vals [4];
    logic          ev;
    vals[0] = 2'b01; vals[1] = 2'b10; vals[2] = 2'b11; vals[3] = 2'b00;
    rdy = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      sin_vld = (c < 4);
      sel     = 2'(c % 4);
      sin     = vals[c % 4];
      #2;
      if (c < 4) begin
        n_checks++;
        if (sin_rdy !== 1'b1) begin
          n_fail++; $display("[TB] FAIL routing_rdy c%0d: got %b expected 1", c, sin_rdy);
        end
      end
      if (c >= 1 && c <= 4) begin
        n_checks++;
        if (vld_v !== (4'b0001 << (c - 1)) || p_arr[c - 1] !== vals[c - 1]) begin
          n_fail++; $display("[TB] FAIL routing_out c%0d: vld=%b data=%b expected vld=%b data=%b",
                             c, vld_v, p_arr[c - 1], 4'b0001 << (c - 1), vals[c - 1]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        ev = (exp_q[k].size() != 0);
        n_checks++;
        if (vld_v[k] !== ev || pend[k] !== ev || (ev && p_arr[k] !== exp_q[k][0])) begin
          n_fail++; $display("[TB] FAIL routing_model ch%0d: vld=%b data=%b expected vld=%b", k, vld_v[k], p_arr[k], ev);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic ev;
    rdy = 4'b1011;
    for (int c = 0; c < 9; c++) begin
      case (c)
        0:       begin sin_vld = 1'b1; sel = 2'd2; sin = 2'b10; end
        1:       begin sin_vld = 1'b1; sel = 2'd0; sin = 2'b11; end
        2, 3, 4: begin sin_vld = 1'b1; sel = 2'd2; sin = 2'b01; end
        5:       begin sin_vld = 1'b1; sel = 2'd2; sin = 2'b01; rdy = 4'b1111; end
        default: begin sin_vld = 1'b0; end
      endcase
      #2;
      if (c >= 2 && c <= 4) begin
        n_checks++;
        if (sin_rdy !== 1'b0 || p2 !== 2'b10 || p2_vld !== 1'b1) begin
          n_fail++; $display("[TB] FAIL stall_hold c%0d: sin_rdy=%b p2=%b vld=%b expected 0/10/1", c, sin_rdy, p2, p2_vld);
        end
      end
      if (c == 1 || c == 5) begin
        n_checks++;
        if (sin_rdy !== 1'b1) begin
          n_fail++; $display("[TB] FAIL stall_accept c%0d: got %b expected 1", c, sin_rdy);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (p0_vld !== 1'b1 || p0 !== 2'b11) begin
          n_fail++; $display("[TB] FAIL stall_isolation: p0=%b vld=%b expected 11/1", p0, p0_vld);
        end
      end
      if (c == 6) begin
        n_checks++;
        if (p2_vld !== 1'b1 || p2 !== 2'b01) begin
          n_fail++; $display("[TB] FAIL stall_second: p2=%b vld=%b expected 01/1", p2, p2_vld);
        end
      end
      for (int k = 0; k < 4; k++) begin
        ev = (exp_q[k].size() != 0);
        n_checks++;
        if (vld_v[k] !== ev || pend[k] !== ev || (ev && p_arr[k] !== exp_q[k][0])) begin
          n_fail++; $display("[TB] FAIL stall_model ch%0d: vld=%b data=%b expected vld=%b", k, vld_v[k], p_arr[k], ev);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic ev;
    rdy = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      sin_vld = (c < 4);
      sel     = 2'd1;
      sin     = 2'(c);
      #2;
      if (c < 4) begin
        n_checks++;
        if (sin_rdy !== 1'b1) begin
          n_fail++; $display("[TB] FAIL b2b_rdy c%0d: got %b expected 1", c, sin_rdy);
        end
      end
      if (c >= 1 && c <= 4) begin
        n_checks++;
        if (p1_vld !== 1'b1 || p1 !== 2'(c - 1)) begin
          n_fail++; $display("[TB] FAIL b2b_out c%0d: p1=%0d vld=%b expected %0d/1", c, p1, p1_vld, c - 1);
        end
      end
      for (int k = 0; k < 4; k++) begin
        ev = (exp_q[k].size() != 0);
        n_checks++;
        if (vld_v[k] !== ev || pend[k] !== ev || (ev && p_arr[k] !== exp_q[k][0])) begin
          n_fail++; $display("[TB] FAIL b2b_model ch%0d: vld=%b data=%b expected vld=%b", k, vld_v[k], p_arr[k], ev);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    rdy = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      sin_vld = 1'b1; sel = 2'(c); sin = 2'(3 - c);
      #2;
      n_checks++;
      if (sin_rdy !== 1'b1) begin
        n_fail++; $display("[TB] FAIL rstmid_fill c%0d: got %b expected 1", c, sin_rdy);
      end
      tick();
    end
    sin_vld = 1'b0;
    #2;
    n_checks++;
    if (pend !== 4'b1111) begin
      n_fail++; $display("[TB] FAIL rstmid_full: pend=%b expected 1111", pend);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    n_checks++;
    if (pend !== 4'b0000 || {p3, p2, p1, p0} !== '0) begin
      n_fail++; $display("[TB] FAIL rstmid_clear: pend=%b data=%h expected 0000/0", pend, {p3, p2, p1, p0});
    end
    rdy = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      tick();
      #2;
      n_checks++;
      if (pend !== 4'b0000) begin
        n_fail++; $display("[TB] FAIL rstmid_stale c%0d: pend=%b expected 0000", c, pend);
      end
    end
  endtask

  task automatic test_random();
    int   beats = 0;
    int   cyc   = 0;
    logic hold  = 1'b0;
    logic ev;
    while (beats < 1000 && cyc < 20000) begin
      if (!hold) begin
        sin_vld = ($urandom_range(0, 3) != 0);
        sel     = 2'($urandom_range(0, 3));
        sin     = DW'($urandom_range(0, 3));
      end
      for (int k = 0; k < 4; k++) rdy[k] = ($urandom_range(0, 2) != 0);
      #2;
      n_checks++;
      if (sin_rdy !== model_rdy()) begin
        n_fail++; $display("[TB] FAIL rand_rdy cyc%0d: got %b expected %b", cyc, sin_rdy, model_rdy());
      end
      for (int k = 0; k < 4; k++) begin
        ev = (exp_q[k].size() != 0);
        n_checks++;
        if (vld_v[k] !== ev || pend[k] !== ev || (ev && p_arr[k] !== exp_q[k][0])) begin
          n_fail++; $display("[TB] FAIL rand_model cyc%0d ch%0d: vld=%b data=%b expected vld=%b",
                             cyc, k, vld_v[k], p_arr[k], ev);
        end
      end
      hold = sin_vld && !model_rdy();
      if (sin_vld && !hold) beats++;
      tick();
      cyc++;
    end
    n_checks++;
    if (beats < 1000) begin
      n_fail++; $display("[TB] FAIL rand_timeout: %0d beats accepted expected 1000", beats);
    end
    sin_vld = 1'b0; rdy = 4'b1111;
    tick();
    tick();
    #2;
    n_checks++;
    if (pend !== 4'b0000 || exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() != 0) begin
      n_fail++; $display("[TB] FAIL rand_drain: pend=%b expected 0000", pend);
    end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_routing();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
